// File: rtl/sisc_fetch_unit_if.sv
// Instruction memory bus between the SISC fetch unit and imem.
// master: fetch side (req/addr out); slave: memory side (ack/rdata out).
interface sisc_fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, imem request handshake, IR and field decode.
// Ports: clk, rst, controller strobes in; imem bus; IR fields, pc_out,
// ir_valid, fetch_busy and sticky fetch_err out.
module sisc_fetch_unit #(
  parameter int                PC_W     = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_rst,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  input  logic              ir_load,
  sisc_fetch_unit_if.master imem,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [3:0]        rd_idx,
  output logic [3:0]        ra_idx,
  output logic [3:0]        rb_idx,
  output logic [15:0]       imm,
  output logic [PC_W-1:0]   pc_out,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Timeout fires on the edge where the counter would reach MAX_WAIT.
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t             state_q, state_n;
  logic               req_q, req_n;
  logic [PC_W-1:0]    addr_q, addr_n;
  logic [7:0]         cnt_q, cnt_n;
  logic [INSTR_W-1:0] ir_q, ir_n;
  logic               vld_q, vld_n;
  logic               err_q, err_n;
  logic [PC_W-1:0]    pc_q, pc_n;
  logic [PC_W-1:0]    next_pc;
  logic [PC_W-1:0]    imm_z, imm_s;

  assign opcode = ir_q[31:28];
  assign mm     = ir_q[27:24];
  assign rd_idx = ir_q[23:20];
  assign ra_idx = ir_q[19:16];
  assign rb_idx = ir_q[15:12];
  assign imm    = ir_q[15:0];

  assign imm_z = PC_W'(imm);
  assign imm_s = PC_W'($signed(imm));

  always_comb begin
    next_pc = pc_q + PC_W'(1);
    unique case ({pc_sel, br_sel})
      2'b11:   next_pc = imm_z;
      2'b10:   next_pc = pc_q + imm_s;
      default: next_pc = pc_q + PC_W'(1);
    endcase
  end

  always_comb begin
    pc_n = pc_q;
    if (pc_rst)
      pc_n = RESET_PC;
    else if (pc_write)
      pc_n = next_pc;
  end

  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    ir_n    = ir_q;
    vld_n   = 1'b0;
    err_n   = err_q;
    unique case (state_q)
      IDLE: begin
        // Fetch address is the PC before any same-cycle pc_write.
        if (ir_load) begin
          addr_n  = pc_q;
          req_n   = 1'b1;
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (ir_load)
          err_n = 1'b1;
        // Abort wins over a coincident ack; that ack is dropped.
        if (pc_rst) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end else if (imem.imem_ack) begin
          ir_n    = imem.imem_rdata;
          req_n   = 1'b0;
          vld_n   = 1'b1;
          state_n = IDLE;
        end else if (cnt_q == LAST) begin
          ir_n    = '0;
          err_n   = 1'b1;
          req_n   = 1'b0;
          vld_n   = 1'b1;
          cnt_n   = cnt_q + 8'd1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      cnt_q   <= cnt_n;
      ir_q    <= ir_n;
      vld_q   <= vld_n;
      err_q   <= err_n;
      pc_q    <= pc_n;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign pc_out         = pc_q;
  assign ir_valid       = vld_q;
  assign fetch_busy     = (state_q == WAIT);
  assign fetch_err      = err_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed self-checking bench for sisc_fetch_unit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic [3:0]  opcode, mm, rd_idx, ra_idx, rb_idx;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        ir_valid, fetch_busy, fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  sisc_fetch_unit_if #(.PC_W(16), .INSTR_W(32)) imem ();

  sisc_fetch_unit #(
    .PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000), .MAX_WAIT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .imem       (imem),
    .opcode     (opcode),
    .mm         (mm),
    .rd_idx     (rd_idx),
    .ra_idx     (ra_idx),
    .rb_idx     (rb_idx),
    .imm        (imm),
    .pc_out     (pc_out),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch: ack on the first WAIT cycle.
  task automatic fetch(input logic [31:0] data, input logic [15:0] addr);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("f_req", 32'(imem.imem_req), 32'd1);
    chk("f_addr", 32'(imem.imem_addr), 32'(addr));
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = data;
    tick();
    imem.imem_ack = 1'b0;
    chk("f_vld", 32'(ir_valid), 32'd1);
    chk("f_imm", 32'(imm), 32'(data[15:0]));
  endtask

  task automatic pcw(input logic sel, input logic br);
    pc_write = 1'b1;
    pc_sel   = sel;
    br_sel   = br;
    tick();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0;
    br_sel = 1'b0; ir_load = 1'b0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_addr", 32'(imem.imem_addr), 32'h0);
    chk("rst_vld", 32'(ir_valid), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_ir", {opcode, mm, rd_idx, ra_idx, imm}, 32'h0);

    // ir_load with pc_write: old PC fetched, PC increments
    ir_load = 1'b1; pc_write = 1'b1;
    tick();
    ir_load = 1'b0; pc_write = 1'b0;
    chk("t1_req", 32'(imem.imem_req), 32'd1);
    chk("t1_busy", 32'(fetch_busy), 32'd1);
    chk("t1_addr", 32'(imem.imem_addr), 32'h0);
    chk("t1_pc", 32'(pc_out), 32'h1);
    chk("t1_vld0", 32'(ir_valid), 32'd0);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1891_0000;
    tick();
    imem.imem_ack = 1'b0;
    chk("t1_vld", 32'(ir_valid), 32'd1);
    chk("t1_req0", 32'(imem.imem_req), 32'd0);
    chk("t1_busy0", 32'(fetch_busy), 32'd0);
    chk("t1_op", 32'(opcode), 32'h1);
    chk("t1_mm", 32'(mm), 32'h8);
    chk("t1_rd", 32'(rd_idx), 32'h9);
    chk("t1_ra", 32'(ra_idx), 32'h1);
    tick();
    chk("t1_pulse", 32'(ir_valid), 32'd0);
    chk("t1_hold", 32'(opcode), 32'h1);

    // ack while idle is ignored
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem.imem_ack = 1'b0;
    chk("idle_ack_op", 32'(opcode), 32'h1);
    chk("idle_ack_vld", 32'(ir_valid), 32'd0);

    // absolute branch to 0x0010, then to 0x0040
    fetch(32'h0000_0010, 16'h0001);
    pcw(1'b1, 1'b1);
    chk("abs10", 32'(pc_out), 32'h0010);
    fetch(32'h0000_0040, 16'h0010);
    pcw(1'b1, 1'b1);
    chk("abs40", 32'(pc_out), 32'h0040);

    // relative 0x0010 + 0xFFF0 wraps to 0
    fetch(32'h0000_0010, 16'h0040);
    pcw(1'b1, 1'b1);
    chk("abs10b", 32'(pc_out), 32'h0010);
    fetch(32'h0000_FFF0, 16'h0010);
    pcw(1'b1, 1'b0);
    chk("rel_wrap", 32'(pc_out), 32'h0000);

    // 0x0002 + 0xFFFE wraps to 0
    pcw(1'b0, 1'b0);
    pcw(1'b0, 1'b0);
    chk("pc2", 32'(pc_out), 32'h0002);
    fetch(32'h0000_FFFE, 16'h0002);
    pcw(1'b1, 1'b0);
    chk("rel_wrap2", 32'(pc_out), 32'h0000);

    // 0xFFFF + 1 wraps
    fetch(32'h0000_FFFF, 16'h0000);
    pcw(1'b1, 1'b1);
    chk("pcffff", 32'(pc_out), 32'hFFFF);
    pcw(1'b0, 1'b0);
    chk("inc_wrap", 32'(pc_out), 32'h0000);
    chk("inc_noerr", 32'(fetch_err), 32'd0);

    // timeout: memory never acks
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!imem.imem_req) break;
      n++;
      tick();
    end
    chk("to_cycles", 32'(n), 32'd15);
    chk("to_vld", 32'(ir_valid), 32'd1);
    chk("to_ir", {opcode, mm, rd_idx, ra_idx, imm}, 32'h0);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_busy", 32'(fetch_busy), 32'd0);

    // pc_rst abort on 3rd WAIT cycle with coincident ack
    fetch(32'h2345_0007, 16'h0000);
    ir_load = 1'b1; pc_write = 1'b1;
    tick();
    ir_load = 1'b0; pc_write = 1'b0;
    chk("ab_pc1", 32'(pc_out), 32'h0001);
    tick();
    tick();
    chk("ab_req", 32'(imem.imem_req), 32'd1);
    pc_rst = 1'b1;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    pc_rst = 1'b0;
    imem.imem_ack = 1'b0;
    chk("ab_pc", 32'(pc_out), 32'h0000);
    chk("ab_req0", 32'(imem.imem_req), 32'd0);
    chk("ab_busy", 32'(fetch_busy), 32'd0);
    chk("ab_vld", 32'(ir_valid), 32'd0);
    chk("ab_ir", {opcode, mm, rd_idx, ra_idx, imm}, 32'h2345_0007);
    tick();
    chk("ab_vld2", 32'(ir_valid), 32'd0);

    // rst clears sticky error; ir_load during WAIT sets it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r2_err", 32'(fetch_err), 32'd0);
    ir_load = 1'b1; pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
    chk("dbl_addr", 32'(imem.imem_addr), 32'h0000);
    tick();
    ir_load = 1'b0;
    chk("dbl_err", 32'(fetch_err), 32'd1);
    chk("dbl_req", 32'(imem.imem_req), 32'd1);
    chk("dbl_addr2", 32'(imem.imem_addr), 32'h0000);
    chk("dbl_pc", 32'(pc_out), 32'h0001);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h3000_0000;
    tick();
    imem.imem_ack = 1'b0;
    chk("dbl_vld", 32'(ir_valid), 32'd1);
    chk("dbl_op", 32'(opcode), 32'h3);
    chk("dbl_busy", 32'(fetch_busy), 32'd0);
    chk("dbl_err2", 32'(fetch_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Upstream neighbour of the SISC control FSM.
- Owns the program counter, the instruction memory request handshake and the instruction register.
- Consumes the controller's pc_rst, pc_write, pc_sel, br_sel and ir_load strobes.
- Presents the decoded opcode, mm and operand fields back to the controller and datapath, and signals fetch_busy so the FSM can hold in fetch while memory is slow.

Parameters:
PC_W, 16, program counter and instruction address width
INSTR_W, 32, instruction width (fields below assume 32)
RESET_PC, 0, PC value after rst or pc_rst
MAX_WAIT, 15, cycles in WAIT without imem_ack before timeout (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
pc_rst  input  1  controller PC reset, synchronous, active-high
pc_write  input  1  update PC this cycle
pc_sel  input  1  0: PC+1, 1: branch target
br_sel  input  1  1: absolute target (imm), 0: relative (PC+imm)
ir_load  input  1  start instruction fetch from current PC
imem_req  output  1  request to instruction memory
imem_addr  output  PC_W  registered fetch address
imem_ack  input  1  memory data valid, one-cycle pulse
imem_rdata  input  INSTR_W  instruction word, valid with imem_ack
opcode  output  4  ir[31:28]
mm  output  4  ir[27:24]
rd_idx  output  4  ir[23:20]
ra_idx  output  4  ir[19:16]
rb_idx  output  4  ir[15:12]
imm  output  16  ir[15:0]
pc_out  output  PC_W  current PC
ir_valid  output  1  one-cycle pulse when IR updated from memory
fetch_busy  output  1  high while a fetch is outstanding
fetch_err  output  1  sticky: timeout or ir_load while busy

Behaviour:
- Reset: rst high at an edge sets
  - PC=RESET_PC, IR=0 (decodes as NOOP)
  - state IDLE, imem_req=0, imem_addr=0
  - ir_valid=0, fetch_busy=0, fetch_err=0, wait counter=0
- PC update priority, highest first:
  - rst
  - pc_rst: PC=RESET_PC
  - pc_write: PC=next_pc
  - otherwise hold.
- next_pc:
  - pc_sel=0: PC+1.
  - pc_sel=1, br_sel=1: imm (truncated or zero-extended to PC_W).
  - pc_sel=1, br_sel=0: PC + sign-extended imm.
  - All arithmetic is modulo 2^PC_W: 0xFFFF+1 -> 0x0000; 0x0002 + 0xFFFE -> 0x0000.
- Fetch FSM states: IDLE, WAIT.
  - IDLE, ir_load=1: latch imem_addr=PC (value before any same-cycle pc_write), set imem_req=1, clear counter, go to WAIT. Address is sampled first, so pc_write with ir_load in the same cycle fetches the old PC and increments the PC.
  - WAIT, imem_ack=1: IR=imem_rdata, imem_req=0, ir_valid=1 for one cycle, go to IDLE. Ack on the first WAIT cycle is legal (zero-wait memory, 2-cycle ir_load-to-ir_valid latency).
  - WAIT, no ack: counter increments. When counter reaches MAX_WAIT: IR=0 (NOOP), fetch_err=1, imem_req=0, ir_valid=1, go to IDLE.
  - imem_ack in IDLE is ignored and IR is unchanged.
  - ir_load while in WAIT: ignored, fetch_err=1, the request continues.
- fetch_busy = (state==WAIT); it is high for every cycle imem_req is high.
- pc_rst while in WAIT: abort the request.
  - imem_req=0, state IDLE, IR unchanged, no ir_valid.
  - An imem_ack arriving on the same edge is discarded.
- imem_addr and imem_req are registered and stable throughout WAIT.
- Field outputs are combinational from IR and hold between fetches. opcode=0xF (HLT) is passed through unchanged; halting is the controller's job.
- fetch_err clears only on rst.

Test Plan:
- Reset then ir_load with pc_write, pc_sel=0, memory ack one cycle after req, rdata=0x1891_0000 -> imem_addr=0, PC=1, ir_valid pulses 2 cycles after ir_load, opcode=1, mm=8, rd_idx=9, ra_idx=1.
- PC=0x0010, pc_write, pc_sel=1, br_sel=1, imm=0x0040 -> PC=0x0040. Repeat with br_sel=0, PC=0x0010, imm=0xFFF0 -> PC=0x0000.
- PC=0xFFFF, pc_write, pc_sel=0 -> PC=0x0000, no error.
- ir_load with memory never acking, MAX_WAIT=15 -> imem_req high exactly 15 cycles, then IR=0, fetch_err=1, ir_valid pulse, fetch_busy low.
- ir_load, then pc_rst on the 3rd WAIT cycle with imem_ack on the same edge -> PC=RESET_PC, imem_req=0, IR holds its prior value, no ir_valid.
- Second ir_load during WAIT -> fetch_err=1; first request completes normally with the original imem_addr.
